// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_pkg
// Description : Shared types and geometry defaults for the data cache.
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    localparam int unsigned c_INDEX_BITS  = 3;
    localparam int unsigned c_OFFSET_BITS = 2;
    localparam int unsigned c_TAG_BITS    = 30 - c_INDEX_BITS - c_OFFSET_BITS;
    localparam int unsigned c_BLOCK_W     = 32 << c_OFFSET_BITS;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        FILL      = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/dcache_array.sv
`default_nettype none
// ============================================================================
// Module      : dcache_array
// Description : Tag/valid/dirty/data storage with word-write and block-fill.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_array
    import dcache_pkg::*;
#(
    parameter int unsigned INDEX_BITS  = c_INDEX_BITS,
    parameter int unsigned OFFSET_BITS = c_OFFSET_BITS,
    parameter int unsigned TAG_BITS    = 30 - INDEX_BITS - OFFSET_BITS,
    parameter int unsigned BLOCK_W     = 32 << OFFSET_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_BITS-1:0]  i_rd_index,
    output logic                   o_rd_valid,
    output logic                   o_rd_dirty,
    output logic [TAG_BITS-1:0]    o_rd_tag,
    output logic [BLOCK_W-1:0]     o_rd_block,
    input  logic                   i_word_we,
    input  logic [INDEX_BITS-1:0]  i_word_index,
    input  logic [OFFSET_BITS-1:0] i_word_offset,
    input  logic [31:0]            i_word_data,
    input  logic                   i_fill_we,
    input  logic [INDEX_BITS-1:0]  i_fill_index,
    input  logic [TAG_BITS-1:0]    i_fill_tag,
    input  logic [BLOCK_W-1:0]     i_fill_block
);

    localparam int unsigned c_LINES = 1 << INDEX_BITS;

    logic [c_LINES-1:0]  r_valid;
    logic [c_LINES-1:0]  r_dirty;
    logic [TAG_BITS-1:0] r_tag  [c_LINES];
    logic [BLOCK_W-1:0]  r_data [c_LINES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill_we) begin
            r_valid[i_fill_index] <= 1'b1;
            r_dirty[i_fill_index] <= 1'b0;
        end else if (i_word_we) begin
            r_dirty[i_word_index] <= 1'b1;
        end
    end

    // Tag and data contents are meaningless while valid is clear, so no reset.
    always_ff @(posedge clk) begin
        if (i_fill_we) begin
            r_tag[i_fill_index]  <= i_fill_tag;
            r_data[i_fill_index] <= i_fill_block;
        end else if (i_word_we) begin
            r_data[i_word_index][{i_word_offset, 5'b00000} +: 32] <= i_word_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_dirty = r_dirty[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_block = r_data[i_rd_index];

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dcache_ctrl
// Description : Direct-mapped write-back write-allocate data cache controller.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int unsigned INDEX_BITS  = c_INDEX_BITS,
    parameter int unsigned OFFSET_BITS = c_OFFSET_BITS
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic                            READ,
    input  logic                            WRITE,
    input  logic [31:0]                     M_ADDRESS,
    input  logic [31:0]                     M_WRITEDATA,
    output logic [31:0]                     M_READDATA,
    output logic                            M_BUSYWAIT,
    output logic                            MEM_READ,
    output logic                            MEM_WRITE,
    output logic [29-OFFSET_BITS:0]         MEM_ADDRESS,
    output logic [(32<<OFFSET_BITS)-1:0]    MEM_WRITEDATA,
    input  logic [(32<<OFFSET_BITS)-1:0]    MEM_READDATA,
    input  logic                            MEM_BUSYWAIT
);

    localparam int unsigned TAG_BITS = 30 - INDEX_BITS - OFFSET_BITS;
    localparam int unsigned BLOCK_W  = 32 << OFFSET_BITS;

    state_e                r_state;
    logic [TAG_BITS-1:0]   r_miss_tag;
    logic [INDEX_BITS-1:0] r_miss_index;
    logic [BLOCK_W-1:0]    r_fill_block;

    logic [OFFSET_BITS-1:0] w_offset;
    logic [INDEX_BITS-1:0]  w_index;
    logic [TAG_BITS-1:0]    w_tag;
    logic                   w_req;
    logic                   w_is_read;
    logic                   w_idle;
    logic                   w_hit;
    logic                   w_rd_valid;
    logic                   w_rd_dirty;
    logic [TAG_BITS-1:0]    w_rd_tag;
    logic [BLOCK_W-1:0]     w_rd_block;
    logic                   w_word_we;
    logic                   w_unused;

    assign w_offset  = M_ADDRESS[OFFSET_BITS+1:2];
    assign w_index   = M_ADDRESS[OFFSET_BITS+INDEX_BITS+1:OFFSET_BITS+2];
    assign w_tag     = M_ADDRESS[31:OFFSET_BITS+INDEX_BITS+2];
    assign w_unused  = ^M_ADDRESS[1:0];

    // A simultaneous READ and WRITE is handled as a write.
    assign w_req     = READ | WRITE;
    assign w_is_read = READ & ~WRITE;
    assign w_idle    = (r_state == IDLE);
    assign w_hit     = w_rd_valid && (w_rd_tag == w_tag);
    assign w_word_we = w_idle & WRITE & w_hit;

    assign M_BUSYWAIT = ~RESET & ((w_req & ~w_hit) | ~w_idle);
    assign M_READDATA = (w_idle & w_is_read & w_hit) ? w_rd_block[{w_offset, 5'b00000} +: 32]
                                                      : 32'h0;

    dcache_array #(
        .INDEX_BITS  (INDEX_BITS),
        .OFFSET_BITS (OFFSET_BITS),
        .TAG_BITS    (TAG_BITS),
        .BLOCK_W     (BLOCK_W)
    ) u_array (
        .clk           (CLK),
        .rst           (RESET),
        .i_rd_index    (w_index),
        .o_rd_valid    (w_rd_valid),
        .o_rd_dirty    (w_rd_dirty),
        .o_rd_tag      (w_rd_tag),
        .o_rd_block    (w_rd_block),
        .i_word_we     (w_word_we),
        .i_word_index  (w_index),
        .i_word_offset (w_offset),
        .i_word_data   (M_WRITEDATA),
        .i_fill_we     (r_state == FILL),
        .i_fill_index  (r_miss_index),
        .i_fill_tag    (r_miss_tag),
        .i_fill_block  (r_fill_block)
    );

    // Miss tag/index are latched so the miss completes even if the CPU withdraws.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state       <= IDLE;
            r_miss_tag    <= '0;
            r_miss_index  <= '0;
            r_fill_block  <= '0;
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDRESS   <= '0;
            MEM_WRITEDATA <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req && !w_hit) begin
                        r_miss_tag   <= w_tag;
                        r_miss_index <= w_index;
                        if (w_rd_valid && w_rd_dirty) begin
                            r_state       <= WRITEBACK;
                            MEM_WRITE     <= 1'b1;
                            MEM_ADDRESS   <= {w_rd_tag, w_index};
                            MEM_WRITEDATA <= w_rd_block;
                        end else begin
                            r_state     <= FETCH;
                            MEM_READ    <= 1'b1;
                            MEM_ADDRESS <= {w_tag, w_index};
                        end
                    end
                end
                WRITEBACK: begin
                    if (!MEM_BUSYWAIT) begin
                        r_state       <= FETCH;
                        MEM_WRITE     <= 1'b0;
                        MEM_WRITEDATA <= '0;
                        MEM_READ      <= 1'b1;
                        MEM_ADDRESS   <= {r_miss_tag, r_miss_index};
                    end
                end
                FETCH: begin
                    if (!MEM_BUSYWAIT) begin
                        r_state      <= FILL;
                        MEM_READ     <= 1'b0;
                        MEM_ADDRESS  <= '0;
                        r_fill_block <= MEM_READDATA;
                    end
                end
                FILL: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_ctrl
// Description : Self-checking bench for dcache_ctrl with a flat-memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

    logic         CLK, RESET, READ, WRITE;
    logic [31:0]  M_ADDRESS, M_WRITEDATA, M_READDATA;
    logic         M_BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_WRITEDATA, MEM_READDATA;

    int n_checks = 0;
    int n_fail   = 0;
    int lat      = 5;
    int mcnt     = 0;

    logic [127:0] mem  [logic [27:0]];
    logic [31:0]  gold [logic [29:0]];
    bit           mv [8];
    bit           md [8];
    logic [24:0]  mt [8];

    int           obs_stalls;
    logic [31:0]  obs_rdata;
    bit           obs_both, obs_rd, obs_wr;
    logic [27:0]  obs_rd_addr, obs_wr_addr;
    logic [127:0] obs_wr_data;

    int           exp_stalls;
    logic [31:0]  exp_rdata;
    bit           exp_wb;
    logic [27:0]  exp_wb_addr, exp_fetch_addr;
    logic [127:0] exp_wb_data;

    dcache_ctrl dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .M_ADDRESS     (M_ADDRESS),
        .M_WRITEDATA   (M_WRITEDATA),
        .M_READDATA    (M_READDATA),
        .M_BUSYWAIT    (M_BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] dflt_word(input logic [29:0] wa);
        return {wa, 2'b01} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] gold_word(input logic [29:0] wa);
        return gold.exists(wa) ? gold[wa] : dflt_word(wa);
    endfunction

    function automatic logic [127:0] gold_block(input logic [27:0] blk);
        logic [127:0] b;
        for (int i = 0; i < 4; i++) b[32*i +: 32] = gold_word({blk, i[1:0]});
        return b;
    endfunction

    function automatic logic [127:0] mem_block(input logic [27:0] blk);
        logic [127:0] b;
        if (mem.exists(blk)) return mem[blk];
        for (int i = 0; i < 4; i++) b[32*i +: 32] = dflt_word({blk, i[1:0]});
        return b;
    endfunction

    // Block memory: busy for lat-1 cycles after a request, then one done cycle.
    initial begin
        MEM_BUSYWAIT = 1'b0;
        MEM_READDATA = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (RESET) begin
                mcnt = 0;
                MEM_BUSYWAIT = 1'b0;
            end else if (MEM_READ || MEM_WRITE) begin
                mcnt++;
                if (mcnt >= lat) begin
                    MEM_BUSYWAIT = 1'b0;
                    if (MEM_WRITE) mem[MEM_ADDRESS] = MEM_WRITEDATA;
                    else           MEM_READDATA = mem_block(MEM_ADDRESS);
                    mcnt = 0;
                end else begin
                    MEM_BUSYWAIT = 1'b1;
                end
            end else begin
                mcnt = 0;
                MEM_BUSYWAIT = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
        end
    endtask

    task automatic model_access(input bit rd, input bit wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input int l);
        logic [2:0]  idx;
        logic [24:0] tag;
        bit          hit;
        idx = addr[6:4];
        tag = addr[31:7];
        hit = mv[idx] && (mt[idx] == tag);
        exp_wb = 1'b0;
        exp_fetch_addr = addr[31:4];
        if (hit) begin
            exp_stalls = 0;
        end else if (mv[idx] && md[idx]) begin
            exp_stalls  = 2 + 2 * l;
            exp_wb      = 1'b1;
            exp_wb_addr = {mt[idx], idx};
            exp_wb_data = gold_block({mt[idx], idx});
        end else begin
            exp_stalls = 2 + l;
        end
        exp_rdata = (rd && !wr) ? gold_word(addr[31:2]) : 32'h0;
        if (!hit) begin
            mv[idx] = 1'b1;
            mt[idx] = tag;
            md[idx] = 1'b0;
        end
        if (wr) begin
            gold[addr[31:2]] = wdata;
            md[idx] = 1'b1;
        end
    endtask

    task automatic cpu_access(input bit rd, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdata);
        @(negedge CLK);
        READ = rd; WRITE = wr; M_ADDRESS = addr; M_WRITEDATA = wdata;
        obs_stalls = 0; obs_both = 0; obs_rd = 0; obs_wr = 0;
        obs_rd_addr = '0; obs_wr_addr = '0; obs_wr_data = '0;
        #1;
        while (M_BUSYWAIT && obs_stalls < 200) begin
            obs_stalls++;
            @(negedge CLK);
            if (MEM_READ && MEM_WRITE) obs_both = 1'b1;
            if (MEM_READ && !obs_rd) begin
                obs_rd = 1'b1;
                obs_rd_addr = MEM_ADDRESS;
            end
            if (MEM_WRITE && !obs_wr) begin
                obs_wr = 1'b1;
                obs_wr_addr = MEM_ADDRESS;
                obs_wr_data = MEM_WRITEDATA;
            end
            #1;
        end
        obs_rdata = M_READDATA;
    endtask

    task automatic test_reset();
        RESET = 1'b1; READ = 1'b1; WRITE = 1'b0;
        M_ADDRESS = 32'h40; M_WRITEDATA = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_checks++;
        if (M_BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL reset_busywait: got %b expected 0", M_BUSYWAIT); end
        n_checks++;
        if (MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0) begin
            n_fail++; $display("FAIL reset_mem_rw: got rd=%b wr=%b expected 0 0", MEM_READ, MEM_WRITE);
        end
        n_checks++;
        if (MEM_ADDRESS !== 28'h0 || MEM_WRITEDATA !== 128'h0) begin
            n_fail++; $display("FAIL reset_mem_bus: got addr=%h data=%h expected 0", MEM_ADDRESS, MEM_WRITEDATA);
        end
        READ = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_first_miss();
        lat = 5;
        mem[28'h4] = {32'hD, 32'hC, 32'hB, 32'hA};
        for (int i = 0; i < 4; i++) gold[{28'h4, i[1:0]}] = 32'hA + i;
        model_access(1, 0, 32'h40, 32'h0, lat);
        cpu_access(1, 0, 32'h40, 32'h0);
        n_checks++;
        if (obs_stalls !== 7) begin n_fail++; $display("FAIL miss_stalls: got %0d expected 7", obs_stalls); end
        n_checks++;
        if (!obs_rd || obs_rd_addr !== 28'h4) begin
            n_fail++; $display("FAIL miss_fetch_addr: got seen=%b addr=%h expected 1 4", obs_rd, obs_rd_addr);
        end
        n_checks++;
        if (obs_rdata !== 32'hA) begin n_fail++; $display("FAIL miss_rdata: got %h expected 0000000a", obs_rdata); end
    endtask

    task automatic test_read_hits();
        logic [31:0] addrs [2];
        logic [31:0] vals  [2];
        addrs[0] = 32'h44; vals[0] = 32'hB;
        addrs[1] = 32'h4C; vals[1] = 32'hD;
        for (int i = 0; i < 2; i++) begin
            model_access(1, 0, addrs[i], 32'h0, lat);
            cpu_access(1, 0, addrs[i], 32'h0);
            n_checks++;
            if (obs_stalls !== 0 || obs_rdata !== vals[i]) begin
                n_fail++;
                $display("FAIL read_hit_%0d: got stalls=%0d data=%h expected 0 %h", i, obs_stalls, obs_rdata, vals[i]);
            end
        end
    endtask

    task automatic test_write_hit();
        model_access(0, 1, 32'h44, 32'h1234_5678, lat);
        cpu_access(0, 1, 32'h44, 32'h1234_5678);
        n_checks++;
        if (obs_stalls !== 0 || obs_rdata !== 32'h0) begin
            n_fail++; $display("FAIL write_hit: got stalls=%0d rdata=%h expected 0 0", obs_stalls, obs_rdata);
        end
        model_access(1, 0, 32'h44, 32'h0, lat);
        cpu_access(1, 0, 32'h44, 32'h0);
        n_checks++;
        if (obs_stalls !== 0 || obs_rdata !== 32'h1234_5678) begin
            n_fail++; $display("FAIL back_to_back_read: got stalls=%0d data=%h expected 0 12345678", obs_stalls, obs_rdata);
        end
    endtask

    task automatic test_dirty_evict();
        lat = 3;
        model_access(1, 0, 32'h444, 32'h0, lat);
        cpu_access(1, 0, 32'h444, 32'h0);
        n_checks++;
        if (obs_stalls !== exp_stalls) begin
            n_fail++; $display("FAIL evict_stalls: got %0d expected %0d", obs_stalls, exp_stalls);
        end
        n_checks++;
        if (!obs_wr || obs_wr_addr !== 28'h4 || obs_wr_data[63:32] !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL evict_writeback: got seen=%b addr=%h word1=%h expected 1 4 12345678",
                     obs_wr, obs_wr_addr, obs_wr_data[63:32]);
        end
        n_checks++;
        if (obs_wr_data !== exp_wb_data) begin
            n_fail++; $display("FAIL evict_block: got %h expected %h", obs_wr_data, exp_wb_data);
        end
        n_checks++;
        if (!obs_rd || obs_rd_addr !== 28'h44 || obs_both) begin
            n_fail++; $display("FAIL evict_fetch: got seen=%b addr=%h both=%b expected 1 44 0", obs_rd, obs_rd_addr, obs_both);
        end
        n_checks++;
        if (obs_rdata !== exp_rdata) begin
            n_fail++; $display("FAIL evict_rdata: got %h expected %h", obs_rdata, exp_rdata);
        end
    endtask

    task automatic test_reset_mid_fetch();
        int waited;
        lat = 5;
        @(negedge CLK);
        READ = 1'b1; WRITE = 1'b0; M_ADDRESS = 32'h40;
        waited = 0;
        while (!MEM_READ && waited < 10) begin
            @(negedge CLK);
            waited++;
        end
        n_checks++;
        if (MEM_READ !== 1'b1) begin n_fail++; $display("FAIL midreset_fetch_start: got %b expected 1", MEM_READ); end
        @(negedge CLK);
        #2 RESET = 1'b1;
        #1;
        n_checks++;
        if (MEM_READ !== 1'b0 || M_BUSYWAIT !== 1'b0 || MEM_ADDRESS !== 28'h0) begin
            n_fail++;
            $display("FAIL midreset_async: got rd=%b busy=%b addr=%h expected 0 0 0", MEM_READ, M_BUSYWAIT, MEM_ADDRESS);
        end
        READ = 1'b0;
        model_reset();
        @(negedge CLK);
        RESET = 1'b0;
        model_access(1, 0, 32'h40, 32'h0, lat);
        cpu_access(1, 0, 32'h40, 32'h0);
        n_checks++;
        if (obs_stalls !== 7 || obs_rdata !== 32'hA) begin
            n_fail++; $display("FAIL midreset_reread: got stalls=%0d data=%h expected 7 0000000a", obs_stalls, obs_rdata);
        end
    endtask

    task automatic test_read_write_both();
        model_access(1, 1, 32'h40, 32'h55, lat);
        cpu_access(1, 1, 32'h40, 32'h55);
        n_checks++;
        if (obs_stalls !== 0 || obs_rdata !== 32'h0) begin
            n_fail++; $display("FAIL rw_both: got stalls=%0d rdata=%h expected 0 0", obs_stalls, obs_rdata);
        end
        model_access(1, 0, 32'h40, 32'h0, lat);
        cpu_access(1, 0, 32'h40, 32'h0);
        n_checks++;
        if (obs_rdata !== 32'h55) begin n_fail++; $display("FAIL rw_both_readback: got %h expected 00000055", obs_rdata); end
    endtask

    task automatic test_withdraw();
        int waited;
        lat = 4;
        model_access(1, 0, 32'h84, 32'h0, lat);
        @(negedge CLK);
        READ = 1'b1; WRITE = 1'b0; M_ADDRESS = 32'h84;
        repeat (2) @(negedge CLK);
        n_checks++;
        if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 28'h8) begin
            n_fail++; $display("FAIL withdraw_fetch: got rd=%b addr=%h expected 1 8", MEM_READ, MEM_ADDRESS);
        end
        READ = 1'b0;
        waited = 0;
        while (M_BUSYWAIT && waited < 30) begin
            @(negedge CLK);
            waited++;
        end
        n_checks++;
        if (M_BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL withdraw_complete: got busy=%b expected 0", M_BUSYWAIT); end
        model_access(1, 0, 32'h84, 32'h0, lat);
        cpu_access(1, 0, 32'h84, 32'h0);
        n_checks++;
        if (obs_stalls !== 0 || obs_rdata !== exp_rdata) begin
            n_fail++;
            $display("FAIL withdraw_filled: got stalls=%0d data=%h expected 0 %h", obs_stalls, obs_rdata, exp_rdata);
        end
    endtask

    task automatic test_random();
        logic [31:0] addr, wdata;
        int          op;
        bit          rd, wr;
        for (int n = 0; n < 80; n++) begin
            lat   = $urandom_range(1, 4);
            addr  = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4) | ($urandom_range(0, 3) << 2);
            wdata = $urandom;
            op    = $urandom_range(0, 2);
            rd    = (op != 1);
            wr    = (op != 0);
            model_access(rd, wr, addr, wdata, lat);
            cpu_access(rd, wr, addr, wdata);
            n_checks++;
            if (obs_stalls !== exp_stalls || obs_rdata !== exp_rdata || obs_both) begin
                n_fail++;
                $display("FAIL rand_%0d addr=%h rd=%b wr=%b: got stalls=%0d data=%h both=%b expected %0d %h 0",
                         n, addr, rd, wr, obs_stalls, obs_rdata, obs_both, exp_stalls, exp_rdata);
            end
            if (exp_wb) begin
                n_checks++;
                if (!obs_wr || obs_wr_addr !== exp_wb_addr || obs_wr_data !== exp_wb_data) begin
                    n_fail++;
                    $display("FAIL rand_wb_%0d: got seen=%b addr=%h data=%h expected 1 %h %h",
                             n, obs_wr, obs_wr_addr, obs_wr_data, exp_wb_addr, exp_wb_data);
                end
            end
            if (exp_stalls != 0) begin
                n_checks++;
                if (!obs_rd || obs_rd_addr !== exp_fetch_addr) begin
                    n_fail++;
                    $display("FAIL rand_fetch_%0d: got seen=%b addr=%h expected 1 %h", n, obs_rd, obs_rd_addr, exp_fetch_addr);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_miss();
        test_read_hits();
        test_write_hit();
        test_dirty_evict();
        test_reset_mid_fetch();
        test_read_write_both();
        test_withdraw();
        test_random();
        @(negedge CLK);
        READ = 1'b0; WRITE = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
